uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_sync.sv | 35 +++
 rtl/uart_rx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver blocks.
//   - uart_state_e         : frame-level state machine encoding (TX and RX)
//   - DELAY_FRAMES_DEFAULT : clock cycles per bit (27 MHz / 115200 baud)
//   - CNT_W                : width of the per-bit cycle counter
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DELAY_FRAMES_DEFAULT = 234;

  // 13 bits covers every legal DELAY_FRAMES value (4..8191).
  localparam int CNT_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Serial line plus received-byte handshake of the UART receiver.
//   i_rx        : serial line into the receiver, idle high
//   o_data      : last correctly received byte
//   o_valid     : one-cycle pulse, o_data carries a new byte
//   o_frame_err : one-cycle pulse, stop bit was sampled low
//   o_busy      : receiver is inside a frame (or waiting out a break)
// Modports:
//   master : line driver / byte consumer (drives i_rx, reads results)
//   slave  : the receiver itself
// -----------------------------------------------------------------------------
interface uart_rx_if;

  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );

  modport slave (
    input  i_rx,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

endinterface

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input bit.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clocks of latency)
// RESET_VAL should match the idle level of the input so that reset release
// does not look like an edge.
// -----------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, sampling each bit at its centre.
//   i_sys_clk : system clock, all logic on its rising edge
//   i_rst_n   : synchronous active-low reset
//   bus       : uart_rx_if.slave (i_rx in; o_data, o_valid, o_frame_err,
//               o_busy out)
// Parameter:
//   DELAY_FRAMES : clock cycles per bit, legal range 4..8191
//
// Timing, with t0 the first cycle the synchronized line is seen low in IDLE:
//   start bit checked at t0 + DELAY_FRAMES/2
//   data bit n sampled at t0 + DELAY_FRAMES/2 + (n+1)*DELAY_FRAMES
//   stop bit sampled at t0 + DELAY_FRAMES/2 + 9*DELAY_FRAMES
// o_valid / o_frame_err are registered and pulse on the clock after the stop
// sample. The FSM is back in IDLE during the o_valid cycle, so a following
// start edge is caught without dead time.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
  input  logic     i_sys_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int HALF_DELAY_WAIT = DELAY_FRAMES / 2;

  // The counter restarts at 0 on each phase, so phase end is "count - 1".
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DELAY_WAIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);

  logic rx_s;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_sys_clk),
    .rst_n (i_rst_n),
    .d     (bus.i_rx),
    .q     (rx_s)
  );

  uart_state_e      state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;

  // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the values
      // present before the edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Counter is held at zero so START begins counting from t0.
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // Line back high at mid-start means a glitch: drop it silently.
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          // Wraps 7 -> 0 exactly on the DATA -> STOP transition.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // A line held low must not be read as a stream of 0x00 frames.
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule
